// File: rtl/mic_arb2.sv
// Two-requester packet arbiter sharing one MIC completer port, with a route FIFO steering responses back.
// Optional MIC_ARB2_ROUND_ROBIN_EN selects round-robin contention; undefined gives fixed M0 priority.
module mic_arb2 #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   M0I_TVALID,
  output logic                   M0I_TREADY,
  input  logic [63:0]            M0I_TDATA,
  input  logic                   M0I_TLAST,
  output logic                   M0O_TVALID,
  input  logic                   M0O_TREADY,
  output logic [63:0]            M0O_TDATA,
  output logic                   M0O_TLAST,
  input  logic                   M1I_TVALID,
  output logic                   M1I_TREADY,
  input  logic [63:0]            M1I_TDATA,
  input  logic                   M1I_TLAST,
  output logic                   M1O_TVALID,
  input  logic                   M1O_TREADY,
  output logic [63:0]            M1O_TDATA,
  output logic                   M1O_TLAST,
  output logic                   S0O_TVALID,
  input  logic                   S0O_TREADY,
  output logic [63:0]            S0O_TDATA,
  output logic                   S0O_TLAST,
  input  logic                   S0I_TVALID,
  output logic                   S0I_TREADY,
  input  logic [63:0]            S0I_TDATA,
  input  logic                   S0I_TLAST,
  output logic [$clog2(DEPTH):0] outstanding
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          grant_r;
  logic          win_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic          head_s;
  logic          s0o_done_s;
  logic          route_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  assign full_s      = (count_r == (AW+1)'(DEPTH));
  assign empty_s     = (count_r == {(AW+1){1'b0}});
  assign head_s      = route_r[rd_ptr_r];
  assign push_s      = (state_r == IDLE) && !full_s && (M0I_TVALID || M1I_TVALID);
  assign pop_s       = S0I_TVALID && S0I_TREADY && S0I_TLAST;
  assign s0o_done_s  = S0O_TVALID && S0O_TREADY && S0O_TLAST;
  assign outstanding = count_r;

`ifdef MIC_ARB2_ROUND_ROBIN_EN
  logic last_r;

  // Contention goes to whoever was not granted last; reset value 1 favours M0.
  always_comb begin
    win_s = 1'b0;
    if (M0I_TVALID && M1I_TVALID) begin
      win_s = ~last_r;
    end else if (M0I_TVALID) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end

  // Round-robin pointer: remembers the most recent grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_r <= 1'b1;
    end else if (push_s) begin
      last_r <= win_s;
    end
  end
`else
  // Fixed priority: M0 wins whenever it is valid.
  always_comb begin
    win_s = 1'b0;
    if (M0I_TVALID) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end
`endif

  // Request FSM state and grant register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      grant_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (push_s) begin
        grant_r <= win_s;
      end
    end
  end

  // Next state: IDLE grants a packet, LOCK holds until its TLAST beat is accepted.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = push_s ? LOCK : IDLE;
      LOCK:    state_nxt_s = s0o_done_s ? IDLE : LOCK;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request steering: only the locked requester sees the downstream channel.
  always_comb begin
    S0O_TVALID = 1'b0;
    S0O_TDATA  = 64'h0;
    S0O_TLAST  = 1'b0;
    M0I_TREADY = 1'b0;
    M1I_TREADY = 1'b0;
    if (state_r == LOCK) begin
      if (grant_r) begin
        S0O_TVALID = M1I_TVALID;
        S0O_TDATA  = M1I_TDATA;
        S0O_TLAST  = M1I_TLAST;
        M1I_TREADY = S0O_TREADY;
      end else begin
        S0O_TVALID = M0I_TVALID;
        S0O_TDATA  = M0I_TDATA;
        S0O_TLAST  = M0I_TLAST;
        M0I_TREADY = S0O_TREADY;
      end
    end else begin
      S0O_TVALID = 1'b0;
    end
  end

  // Response steering by route FIFO head; an empty FIFO stalls stray responses.
  always_comb begin
    M0O_TVALID = 1'b0;
    M0O_TDATA  = 64'h0;
    M0O_TLAST  = 1'b0;
    M1O_TVALID = 1'b0;
    M1O_TDATA  = 64'h0;
    M1O_TLAST  = 1'b0;
    S0I_TREADY = 1'b0;
    if (!empty_s) begin
      if (head_s) begin
        M1O_TVALID = S0I_TVALID;
        M1O_TDATA  = S0I_TDATA;
        M1O_TLAST  = S0I_TLAST;
        S0I_TREADY = M1O_TREADY;
      end else begin
        M0O_TVALID = S0I_TVALID;
        M0O_TDATA  = S0I_TDATA;
        M0O_TLAST  = S0I_TLAST;
        S0I_TREADY = M0O_TREADY;
      end
    end else begin
      S0I_TREADY = 1'b0;
    end
  end

  // Route FIFO storage, pointers and occupancy counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        route_r[i] <= 1'b0;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        route_r[wr_ptr_r] <= win_s;
        wr_ptr_r          <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
